// File: rtl/console_write_arbiter.sv
// console_write_arbiter: shares the console RAM write port between two requesters, with a built-in clear sweep.
// Define CONSOLE_ARB_FIXED_PRIORITY_EN to make req0 always win contention instead of round-robin.
module console_write_arbiter #(
  parameter int unsigned CONSOLE_ADDR_MAX = 2399,
  parameter logic [7:0]  FILL_CHAR        = 8'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        req0_valid,
  input  logic [11:0] req0_addr,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [11:0] req1_addr,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [11:0] console_addr,
  output logic        console_write,
  output logic [7:0]  console_data,
  output logic        busy,
  output logic [7:0]  drop_count
);
  localparam logic [0:0]  IDLE  = 1'b0;
  localparam logic [0:0]  CLEAR = 1'b1;
  localparam logic [11:0] AMAX  = 12'(CONSOLE_ADDR_MAX);
  logic [0:0]  state_q, state_d;
  logic [11:0] sweep_q, sweep_d, addr_q, addr_d, sel_addr;
  logic [7:0]  data_q, data_d, drop_q, drop_d, sel_data;
  logic        write_q, write_d, busy_q, busy_d;
  logic        idle, g0, g1, xfer;
  // clear pre-empts any request in the cycle it is seen
  assign idle = !reset && !clear && state_q == IDLE;
`ifdef CONSOLE_ARB_FIXED_PRIORITY_EN
  assign g0 = idle && req0_valid;
  assign g1 = idle && req1_valid && !req0_valid;
`else
  logic lg_q, lg_d;
  assign g0   = idle && req0_valid && (!req1_valid || lg_q);
  assign g1   = idle && req1_valid && (!req0_valid || !lg_q);
  assign lg_d = (g0 || g1) && req0_valid && req1_valid ? g1 : lg_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) lg_q <= 1'b1;
    else       lg_q <= lg_d;
`endif
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign xfer       = g0 || g1;
  assign sel_addr   = g1 ? req1_addr : req0_addr;
  assign sel_data   = g1 ? req1_data : req0_data;
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = 1'b0;
    busy_d  = busy_q;
    drop_d  = drop_q;
    if (state_q == CLEAR) begin
      write_d = 1'b1;
      addr_d  = sweep_q;
      data_d  = FILL_CHAR;
      sweep_d = sweep_q == AMAX ? sweep_q : sweep_q + 12'd1;
      state_d = sweep_q == AMAX ? IDLE : CLEAR;
      busy_d  = sweep_q != AMAX;
    end else if (clear) begin
      state_d = CLEAR;
      sweep_d = '0;
      busy_d  = 1'b1;
    end else if (xfer && sel_addr <= AMAX) begin
      write_d = 1'b1;
      addr_d  = sel_addr;
      data_d  = sel_data;
    end else if (xfer) begin
      drop_d = drop_q + {7'd0, drop_q != 8'hFF};
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      sweep_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  assign console_addr  = addr_q;
  assign console_data  = data_q;
  assign console_write = write_q;
  assign busy          = busy_q;
  assign drop_count    = drop_q;
endmodule

// File: tb/tb_console_write_arbiter.sv
// tb_console_write_arbiter: scoreboard bench; stimulus pushes expected console writes, a negedge monitor pops and compares.
module tb_console_write_arbiter;
  logic        clock = 1'b0, reset = 1'b1, clear = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [11:0] req0_addr = '0, req1_addr = '0;
  logic [7:0]  req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, console_write, busy;
  logic [11:0] console_addr;
  logic [7:0]  console_data, drop_count;

  console_write_arbiter dut (
    .clock(clock), .reset(reset), .clear(clear),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .console_addr(console_addr), .console_write(console_write), .console_data(console_data),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t q[$];
  int  cyc = 0, errors = 0, checks = 0, busy_left = 0, drops = 0;
  bit  lg = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a clear books 2400 fill writes up front; a granted in-range request books one write next cycle.
  task automatic step(input bit v0, input logic [11:0] a0, input logic [7:0] d0,
                      input bit v1, input logic [11:0] a1, input logic [7:0] d1, input bit clr);
    bit was_busy, idle, e0, e1, pd;
    logic [11:0] a;
    logic [7:0]  d;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clear = clr;
    #1;
    was_busy = busy_left > 0;
    idle = !was_busy && !clr;
`ifdef CONSOLE_ARB_FIXED_PRIORITY_EN
    e0 = idle && v0;
    e1 = idle && v1 && !v0;
`else
    if (v0 && v1) begin
      e0 = idle && lg;
      e1 = idle && !lg;
    end else begin
      e0 = idle && v0;
      e1 = idle && v1;
    end
`endif
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    pd = 1'b0;
    if (!was_busy && clr) begin
      for (int k = 0; k < 2400; k++) q.push_back('{a: 12'(k), d: 8'h20, c: cyc + 2 + k});
    end else if (e0 || e1) begin
      a = e1 ? a1 : a0;
      d = e1 ? d1 : d0;
      if (a <= 12'd2399) q.push_back('{a: a, d: d, c: cyc + 1});
      else pd = drops < 255;
      if (v0 && v1) lg = e1;
    end
    @(posedge clock);
    if (was_busy) busy_left--;
    else if (clr) busy_left = 2400;
    if (pd) drops++;
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_step(input bit clr);
    logic [11:0] a0, a1;
    a0 = $urandom_range(0, 9) == 0 ? 12'($urandom_range(2400, 4095)) : 12'($urandom_range(0, 2399));
    a1 = $urandom_range(0, 9) == 0 ? 12'($urandom_range(2400, 4095)) : 12'($urandom_range(0, 2399));
    step(1'($urandom_range(0, 1)), a0, 8'($urandom), 1'($urandom_range(0, 1)), a1, 8'($urandom), clr);
  endtask

  always @(negedge clock) begin
    bit exp_w;
    wr_t e;
    if (!reset) begin
      chk("busy", busy, busy_left > 0);
      chk("drop_count", drop_count, drops);
      exp_w = q.size() > 0 && q[0].c == cyc;
      chk("console_write", console_write, exp_w);
      if (exp_w) begin
        e = q.pop_front();
        chk("console_addr", console_addr, e.a);
        chk("console_data", console_data, e.d);
      end
    end
  end

  initial begin
    req0_valid = 1'b1;
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_write", console_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_addr", console_addr, 0);
    req0_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    step(1, 12'd5, 8'h41, 0, 0, 0, 0);
    idle_steps(2);
    for (int i = 0; i < 4; i++) step(1, 12'(10 + i), 8'(8'h30 + i), 1, 12'(20 + i), 8'(8'h60 + i), 0);
    step(0, 0, 0, 1, 12'd2400, 8'h55, 0);
    idle_steps(2);
    step(0, 0, 0, 1, 12'd7, 8'h42, 1);
    for (int i = 0; i < 2402; i++) step(0, 0, 0, 1, 12'd7, 8'h42, 0);
    idle_steps(2);
    for (int i = 0; i < 1500; i++) rnd_step($urandom_range(0, 299) == 0);
    while (busy_left > 0) rnd_step(0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle_steps(1001);
    chk("sweep_at_1000", console_addr, 1000);
    #1 reset = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_write", console_write, 0);
    chk("abort_ready1", req1_ready, 0);
    chk("abort_drop", drop_count, 0);
    q.delete();
    busy_left = 0;
    drops = 0;
    lg = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2405; i++) begin
      if (i == 501) step(1, 12'd3, 8'h11, 0, 0, 0, 1);
      else rnd_step(0);
    end
    for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 12'd2400, 8'h99, 0);
    idle_steps(3);
    chk("drop_saturated", drop_count, 255);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
